modular_square_iter_wrapper: RTL

//  Single-clock, parametrised I/O wrapper plus iteration controller for a free-running modular squaring core.

---
 rtl/modular_square_iter_wrapper_if.sv | 40 ++++
 rtl/modular_square_iter_wrapper.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/modular_square_iter_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : modular_square_iter_wrapper_if
// Description : Bus between the iteration wrapper and a free-running modular
//               squaring core.
//               master (wrapper side): drives core_reset, core_start and
//                                      core_sq_in; receives core_sq_out and
//                                      core_valid.
//               slave  (core side)   : the mirror image.
//               Coefficient j of either data bus sits at
//               [j*BIT_LEN +: BIT_LEN].
// Revision    : 1.0 - initial release
// ============================================================================
interface modular_square_iter_wrapper_if #(
    parameter int NUM_ELEMENTS = 66,
    parameter int BIT_LEN      = 17
);
    logic                            core_reset;
    logic                            core_start;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_in;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_out;
    logic                            core_valid;

    modport master (
        output core_reset,
        output core_start,
        output core_sq_in,
        input  core_sq_out,
        input  core_valid
    );

    modport slave (
        input  core_reset,
        input  core_start,
        input  core_sq_in,
        output core_sq_out,
        output core_valid
    );
endinterface
`default_nettype wire

// File: rtl/modular_square_iter_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : modular_square_iter_wrapper
// Description : I/O wrapper and iteration controller for a free-running
//               modular squaring core. Splits sq_in into core coefficients,
//               launches the core, counts its per-squaring valid pulses and,
//               after the requested number of squarings, captures the result,
//               stops the core and presents a packed sq_out with a valid pulse.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start, abort    - run request (IDLE only) / run cancel
//               iterations      - squarings to perform, sampled with start
//               sq_in           - initial value, sampled with start
//               sq_out, valid   - packed result coefficients, 1-cycle pulse
//               busy            - high outside IDLE
//               iter_count      - squarings completed in current/last run
//               core            - master side of the core bus
// Revision    : 1.0 - initial release
// ============================================================================
module modular_square_iter_wrapper #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int BIT_LEN            = 17,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int OUT_WORD           = 32,
    parameter int IN_STAGES          = 3,
    parameter int OUT_STAGES         = 3,
    parameter int ITER_W             = 64,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ITER_W-1:0]                iterations,
    input  logic [MOD_LEN-1:0]               sq_in,
    output logic [NUM_ELEMENTS*OUT_WORD-1:0] sq_out,
    output logic                             valid,
    output logic                             busy,
    output logic [ITER_W-1:0]                iter_count,
    modular_square_iter_wrapper_if.master    core
);
    localparam int c_NUM_WORDS = MOD_LEN / WORD_LEN;
    localparam int c_CORE_W    = NUM_ELEMENTS * BIT_LEN;
    localparam int c_OUT_W     = NUM_ELEMENTS * OUT_WORD;
    localparam int c_CNT_MAX   = (IN_STAGES > OUT_STAGES + 1) ? IN_STAGES : OUT_STAGES + 1;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_LOAD_LAST  = c_CNT_W'(IN_STAGES - 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(OUT_STAGES);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_FLUSH = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_accept;
    logic                w_core_start;
    logic                w_count;
    logic                w_capture;

    logic [c_CORE_W-1:0] w_split;
    logic [c_OUT_W-1:0]  w_in_pack;
    logic [c_OUT_W-1:0]  w_dpack;
    logic [c_CORE_W-1:0] r_in_pipe     [IN_STAGES];
    logic                r_dvalid_pipe [OUT_STAGES];
    logic [c_CORE_W-1:0] r_ddata_pipe  [OUT_STAGES];
    logic                w_dvalid;
    logic [c_CORE_W-1:0] w_ddata;

    logic [ITER_W-1:0]   r_iters;
    logic [ITER_W-1:0]   r_iter_count;
    logic [c_OUT_W-1:0]  r_sq_out;
    logic                r_valid;

    assign w_dvalid = r_dvalid_pipe[OUT_STAGES-1];
    assign w_ddata  = r_ddata_pipe[OUT_STAGES-1];

    // Coefficient split of the input, packing of the input (zero-iteration
    // bypass) and packing of the delayed core result.
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_coeff
        if (j < c_NUM_WORDS) begin : g_word
            assign w_split[j*BIT_LEN +: BIT_LEN]    = BIT_LEN'(sq_in[j*WORD_LEN +: WORD_LEN]);
            assign w_in_pack[j*OUT_WORD +: OUT_WORD] = OUT_WORD'(sq_in[j*WORD_LEN +: WORD_LEN]);
        end else begin : g_redundant
            assign w_split[j*BIT_LEN +: BIT_LEN]    = '0;
            assign w_in_pack[j*OUT_WORD +: OUT_WORD] = '0;
        end
        assign w_dpack[j*OUT_WORD +: OUT_WORD] = OUT_WORD'(w_ddata[j*BIT_LEN +: BIT_LEN]);
    end

    // Next-state and control decode. Abort takes priority over both the
    // core launch and a coincident final dvalid.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_core_start = 1'b0;
        w_count      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (iterations != '0) w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = c_ST_STOP;
                end else if (r_cnt == c_LOAD_LAST) begin
                    w_core_start = 1'b1;
                    w_state_nxt  = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_state_nxt = c_ST_STOP;
                end else if (w_dvalid) begin
                    w_count = 1'b1;
                    if (r_iter_count + ITER_W'(1) == r_iters) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_ST_STOP;
                    end
                end
            end
            c_ST_STOP:  w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: if (r_cnt == c_FLUSH_LAST) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register; r_cnt restarts on every state change so LOAD and FLUSH
    // durations are measured from their entry edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else                        r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Input and output pipelines. Stage 0 of the input pipe only loads on an
    // accepted start; every other stage shifts each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IN_STAGES; i++) r_in_pipe[i] <= '0;
            for (int i = 0; i < OUT_STAGES; i++) begin
                r_dvalid_pipe[i] <= 1'b0;
                r_ddata_pipe[i]  <= '0;
            end
        end else begin
            if (w_accept) r_in_pipe[0] <= w_split;
            for (int i = 1; i < IN_STAGES; i++) r_in_pipe[i] <= r_in_pipe[i-1];
            r_dvalid_pipe[0] <= core.core_valid;
            r_ddata_pipe[0]  <= core.core_sq_out;
            for (int i = 1; i < OUT_STAGES; i++) begin
                r_dvalid_pipe[i] <= r_dvalid_pipe[i-1];
                r_ddata_pipe[i]  <= r_ddata_pipe[i-1];
            end
        end
    end

    // Run bookkeeping and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iters      <= '0;
            r_iter_count <= '0;
            r_sq_out     <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_iters      <= iterations;
                r_iter_count <= '0;
                if (iterations == '0) begin
                    r_sq_out <= w_in_pack;
                    r_valid  <= 1'b1;
                end
            end
            if (w_count) r_iter_count <= r_iter_count + ITER_W'(1);
            if (w_capture) begin
                r_sq_out <= w_dpack;
                r_valid  <= 1'b1;
            end
        end
    end

    assign sq_out          = r_sq_out;
    assign valid           = r_valid;
    assign busy            = (r_state != c_ST_IDLE);
    assign iter_count      = r_iter_count;
    assign core.core_reset = reset | (r_state == c_ST_STOP);
    assign core.core_start = w_core_start;
    assign core.core_sq_in = r_in_pipe[IN_STAGES-1];
endmodule
`default_nettype wire
